bfs_node_walker: RTL

Breadth-first traversal sequencer for the octree node BRAM in the octant core. Given a root address, it drives the BRAM read port, unpacks each 152-bit node word and queues the non-null child pointers in an internal FIFO. It emits visited nodes in BFS order to a downstream consumer over a valid/ready handshake. It is the only reader of the node BRAM during traversal; the builder keeps the write port.

---
 rtl/bfs_node_walker.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/bfs_node_walker.sv
// rtl/bfs_node_walker.sv - breadth-first octree node walker over a 1-cycle-latency node BRAM
// Optional loop guard: define BFS_LOOP_GUARD_EN to cap a traversal at DEPTH emitted nodes.
module bfs_node_walker #(
  parameter int WIDTH  = 152,
  parameter int DEPTH  = 16,
  parameter int QDEPTH = 16,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [ADDRW-1:0] i_root_addr,
  output logic [ADDRW-1:0] o_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_node_valid,
  input  logic             i_node_ready,
  output logic [ADDRW-1:0] o_node_addr,
  output logic [3:0]       o_node_depth,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_loop_abort,
  output logic [ADDRW:0]   o_visit_count
);

  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);
`ifdef BFS_LOOP_GUARD_EN
  localparam logic [ADDRW:0] VISIT_LIMIT = (ADDRW+1)'(DEPTH);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_SCAN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] cur_addr_q, cur_addr_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] node_q, node_d;
  logic [2:0]       idx_q, idx_d;
  logic [ADDRW:0]   visit_q, visit_d;
  logic             ovf_q, ovf_d;
  logic             abort_q, abort_d;
  logic             from_fifo_q, from_fifo_d;

  logic [ADDRW-1:0] fifo_mem [QDEPTH];
  logic [QW-1:0]    fifo_wr_q, fifo_rd_q;
  logic [QW:0]      fifo_cnt_q;
  logic             fifo_full, fifo_empty_next;
  logic             push, pop, flush;

  logic [15:0]      children [8];
  logic [15:0]      child_ptr;
  logic             child_live;
  logic [ADDRW-1:0] fetch_addr;
  logic             unused_fields;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      children[k] = node_q[151-16*k -: 16];
    end
  end

  assign child_ptr     = children[idx_q];
  assign child_live    = |child_ptr;
  assign fifo_full     = (fifo_cnt_q == QFULL);
  assign fetch_addr    = from_fifo_q ? fifo_mem[fifo_rd_q] : cur_addr_q;
  assign unused_fields = ^{node_q[23:8], node_q[3:0]};

  // Pops happen in FETCH so the last SCAN cycle can still push without a same-cycle pop.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    rd_addr_d       = rd_addr_q;
    node_d          = node_q;
    idx_d           = idx_q;
    visit_d         = visit_q;
    ovf_d           = ovf_q;
    abort_d         = abort_q;
    from_fifo_d     = from_fifo_q;
    push            = 1'b0;
    pop             = 1'b0;
    flush           = 1'b0;
    fifo_empty_next = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cur_addr_d  = i_root_addr;
          ovf_d       = 1'b0;
          abort_d     = 1'b0;
          visit_d     = '0;
          from_fifo_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        cur_addr_d = fetch_addr;
        rd_addr_d  = fetch_addr;
        pop        = from_fifo_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        node_d  = i_rd_data;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (i_node_ready) begin
          visit_d = visit_q + (ADDRW+1)'(1);
          idx_d   = 3'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (child_live) begin
          if (fifo_full) ovf_d = 1'b1;
          else           push  = 1'b1;
        end
        idx_d = idx_q + 3'd1;
        fifo_empty_next = (fifo_cnt_q == '0) && !push;
        if (idx_q == 3'd7) begin
          if (fifo_empty_next) begin
            state_d = S_DONE;
          end
`ifdef BFS_LOOP_GUARD_EN
          else if (visit_q == VISIT_LIMIT) begin
            abort_d = 1'b1;
            state_d = S_DONE;
          end
`endif
          else begin
            from_fifo_d = 1'b1;
            state_d     = S_FETCH;
          end
        end
      end
      S_DONE: begin
        flush   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      rd_addr_q   <= '0;
      node_q      <= '0;
      idx_q       <= '0;
      visit_q     <= '0;
      ovf_q       <= 1'b0;
      abort_q     <= 1'b0;
      from_fifo_q <= 1'b0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rd_addr_q   <= rd_addr_d;
      node_q      <= node_d;
      idx_q       <= idx_d;
      visit_q     <= visit_d;
      ovf_q       <= ovf_d;
      abort_q     <= abort_d;
      from_fifo_q <= from_fifo_d;
      if (flush) begin
        fifo_wr_q  <= '0;
        fifo_rd_q  <= '0;
        fifo_cnt_q <= '0;
      end else if (push) begin
        fifo_wr_q  <= fifo_wr_q + QW'(1);
        fifo_cnt_q <= fifo_cnt_q + (QW+1)'(1);
      end else if (pop) begin
        fifo_rd_q  <= fifo_rd_q + QW'(1);
        fifo_cnt_q <= fifo_cnt_q - (QW+1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[fifo_wr_q] <= child_ptr[ADDRW-1:0];
  end

  assign o_rd_addr     = (state_q == S_FETCH) ? fetch_addr : rd_addr_q;
  assign o_node_valid  = (state_q == S_EMIT);
  assign o_node_addr   = cur_addr_q;
  assign o_node_depth  = node_q[7:4];
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_overflow    = ovf_q;
  assign o_loop_abort  = abort_q;
  assign o_visit_count = visit_q;

endmodule
